// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, then clocks out one byte
// plus odd parity and stop under device clocking, and finally checks the device ACK.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 12000,
  parameter int unsigned START_TIMEOUT  = 1500000,
  parameter int unsigned XFER_TIMEOUT   = 200000,
  parameter int unsigned FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  output logic [1:0] err_code,
  output logic       rx_inhibit,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int CNT_W  = 21;
  localparam int FILT_W = $clog2(FILTER_LEN + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_INHIBIT, S_RTS, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE, S_DONE, S_ERR
  } state_t;

  state_t             state_q;
  logic               clk_s1_q, clk_s2_q, data_s1_q, data_s2_q;
  logic               clk_filt_q;
  logic [FILT_W-1:0]  filt_cnt_q;
  logic [CNT_W-1:0]   timer_q;
  logic [3:0]         bitcnt_q;
  logic [7:0]         data_q;
  logic               par_q;
  logic               busy_q, done_q, error_q, clk_oe_q, data_oe_q;
  logic [1:0]         err_code_q;

  logic               filt_flip_d, fall_d, xfer_expired_d;
  logic [CNT_W-1:0]   timer_inc_d;
  logic [2:0]         next_idx_d;

  // NOTE: the idle bus is pulled high, so the synchronizers and filter reset to 1;
  // resetting them to 0 would manufacture a fake rising edge after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_s1_q  <= 1'b1;
      clk_s2_q  <= 1'b1;
      data_s1_q <= 1'b1;
      data_s2_q <= 1'b1;
    end else begin
      clk_s1_q  <= ps2_clk_in;
      clk_s2_q  <= clk_s1_q;
      data_s1_q <= ps2_data_in;
      data_s2_q <= data_s1_q;
    end
  end

  // The filtered clock flips only after FILTER_LEN consecutive samples disagree with it.
  assign filt_flip_d = (clk_s2_q != clk_filt_q) && (filt_cnt_q == FILT_W'(FILTER_LEN - 1));
  assign fall_d      = filt_flip_d && clk_filt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_filt_q <= 1'b1;
      filt_cnt_q <= '0;
    end else if (clk_s2_q == clk_filt_q) begin
      filt_cnt_q <= '0;
    end else if (filt_flip_d) begin
      clk_filt_q <= clk_s2_q;
      filt_cnt_q <= '0;
    end else begin
      filt_cnt_q <= filt_cnt_q + 1'b1;
    end
  end

  assign timer_inc_d    = (&timer_q) ? timer_q : timer_q + 1'b1;
  assign xfer_expired_d = (timer_q == CNT_W'(XFER_TIMEOUT - 1));
  assign next_idx_d     = bitcnt_q[2:0] + 3'd1;

  // NOTE: every register in this FSM uses non-blocking assignment, so each branch
  // reads the pre-edge values of timer_q, bitcnt_q and data_oe_q regardless of order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      bitcnt_q   <= '0;
      data_q     <= '0;
      par_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_code_q <= 2'b00;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (tx_start && !busy_q) begin
            data_q   <= tx_data;
            par_q    <= ~^tx_data;
            busy_q   <= 1'b1;
            clk_oe_q <= 1'b1;
            timer_q  <= '0;
            state_q  <= S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          // data_oe_q set means the terminal count passed last cycle: release the clock.
          if (data_oe_q) begin
            clk_oe_q <= 1'b0;
            timer_q  <= '0;
            state_q  <= S_RTS;
          end else if (timer_q == CNT_W'(INHIBIT_CYCLES - 1)) begin
            data_oe_q <= 1'b1;
          end else begin
            timer_q <= timer_inc_d;
          end
        end
        S_RTS: begin
          if (fall_d) begin
            bitcnt_q  <= '0;
            data_oe_q <= ~data_q[0];
            timer_q   <= '0;
            state_q   <= S_DATA;
          end else if (timer_q == CNT_W'(START_TIMEOUT - 1)) begin
            clk_oe_q   <= 1'b0;
            data_oe_q  <= 1'b0;
            busy_q     <= 1'b0;
            error_q    <= 1'b1;
            err_code_q <= 2'b01;
            state_q    <= S_ERR;
          end else begin
            timer_q <= timer_inc_d;
          end
        end
        S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE: begin
          timer_q <= timer_inc_d;
          if (xfer_expired_d) begin
            data_oe_q  <= 1'b0;
            busy_q     <= 1'b0;
            error_q    <= 1'b1;
            err_code_q <= 2'b10;
            state_q    <= S_ERR;
          end else begin
            unique case (state_q)
              S_DATA: begin
                if (fall_d) begin
                  if (bitcnt_q == 4'd7) begin
                    data_oe_q <= ~par_q;
                    state_q   <= S_PARITY;
                  end else begin
                    bitcnt_q  <= bitcnt_q + 4'd1;
                    data_oe_q <= ~data_q[next_idx_d];
                  end
                end
              end
              S_PARITY: begin
                if (fall_d) begin
                  data_oe_q <= 1'b0;
                  state_q   <= S_STOP;
                end
              end
              S_STOP: begin
                if (fall_d) begin
                  if (!data_s2_q) begin
                    state_q <= S_WAIT_IDLE;
                  end else begin
                    busy_q     <= 1'b0;
                    error_q    <= 1'b1;
                    err_code_q <= 2'b11;
                    state_q    <= S_ERR;
                  end
                end
              end
              default: begin
                if (clk_filt_q && data_s2_q) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
                end
              end
            endcase
          end
        end
        S_DONE, S_ERR: state_q <= S_IDLE;
        default:       state_q <= S_IDLE;
      endcase
    end
  end

  assign tx_busy     = busy_q;
  assign rx_inhibit  = busy_q;
  assign tx_done     = done_q;
  assign tx_error    = error_q;
  assign err_code    = err_code_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;

endmodule
